// File: rtl/api_job_sched.sv
// -----------------------------------------------------------------------------
// api_job_sched
//   Moves fixed-length jobs of 32-bit words from one of two sources into a tx
//   FIFO. A job starts only when the FIFO has room for the whole job. The two
//   sources are served round-robin, one whole job at a time. A job whose
//   source goes quiet for too long is completed with zero words and flagged.
//
// Handshake: a source word moves on a rising edge where srcN_vld and srcN_rdy
//   are both high. srcN_rdy depends only on registered state, never on vld.
//   The FIFO write side has no back-pressure; tx_fifo_wr_en is a write strobe.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   reg_en              scheduler enable, sampled only when idle
//   reg_word_num[7:0]   words per job, sampled only at job start
//   err_clr             clears err_abort (a simultaneous set wins)
//   src0_vld/dat/rdy    job source 0 word handshake
//   src1_vld/dat/rdy    job source 1 word handshake
//   tx_fifo_wr_en/din   tx FIFO write strobe and data
//   tx_fifo_data_count  tx FIFO occupancy in words
//   busy                a job is in progress (XFER, PAD or GAP)
//   grant[1:0]          one-hot owner of the current job, 0 when idle
//   job_cnt[15:0]       completed jobs (aborted jobs included), wraps
//   err_abort           sticky: a job was aborted for a stalled source
// -----------------------------------------------------------------------------
module api_job_sched #(
    parameter int TX_FIFO_DEPTH = 512,
    parameter int STALL_MAX     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_en,
    input  logic [7:0]  reg_word_num,
    input  logic        err_clr,
    input  logic        src0_vld,
    input  logic [31:0] src0_dat,
    output logic        src0_rdy,
    input  logic        src1_vld,
    input  logic [31:0] src1_dat,
    output logic        src1_rdy,
    output logic        tx_fifo_wr_en,
    output logic [31:0] tx_fifo_din,
    input  logic [9:0]  tx_fifo_data_count,
    output logic        busy,
    output logic [1:0]  grant,
    output logic [15:0] job_cnt,
    output logic        err_abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int                 STALL_W    = $clog2(STALL_MAX + 1);
    // The abort fires on the idle cycle that brings the count to STALL_MAX.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam logic [31:0]        DEPTH      = 32'(TX_FIFO_DEPTH);

    state_t             state;
    logic [7:0]         job_len;
    logic [7:0]         word_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               prefer_src1;   // set when the last completed job was src0

    logic [31:0] count_ext;
    logic        space_ok;
    logic        start;
    logic        pick_src1;
    logic        g_vld;
    logic [31:0] g_dat;
    logic        xfer_hs;
    logic        last_word;
    logic        stall_abort;

    // Room check; an occupancy above DEPTH is treated as no room at all.
    assign count_ext = {22'd0, tx_fifo_data_count};
    assign space_ok  = (count_ext <= DEPTH) &&
                       ((DEPTH - count_ext) >= {24'd0, reg_word_num});

    assign start = reg_en && (reg_word_num != 8'd0) && space_ok &&
                   (src0_vld || src1_vld);

    // src1 wins only when it is alone or when it is src1's turn.
    assign pick_src1 = src1_vld && (!src0_vld || prefer_src1);

    assign g_vld = grant[0] ? src0_vld : (grant[1] && src1_vld);
    assign g_dat = grant[0] ? src0_dat : src1_dat;

    assign xfer_hs     = (state == XFER) && g_vld;
    assign last_word   = ((word_cnt + 8'd1) == job_len);
    assign stall_abort = (state == XFER) && !g_vld && (stall_cnt == STALL_LAST);

    assign src0_rdy      = (state == XFER) && grant[0];
    assign src1_rdy      = (state == XFER) && grant[1];
    assign tx_fifo_wr_en = xfer_hs || (state == PAD);
    assign tx_fifo_din   = xfer_hs ? g_dat : 32'h0;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            job_len     <= 8'd0;
            word_cnt    <= 8'd0;
            stall_cnt   <= '0;
            prefer_src1 <= 1'b0;
            grant       <= 2'b00;
            job_cnt     <= 16'd0;
            err_abort   <= 1'b0;
        end else begin
            if (stall_abort) begin
                err_abort <= 1'b1;
            end else if (err_clr) begin
                err_abort <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= XFER;
                        job_len   <= reg_word_num;
                        word_cnt  <= 8'd0;
                        stall_cnt <= '0;
                        grant     <= pick_src1 ? 2'b10 : 2'b01;
                    end
                end
                XFER: begin
                    if (xfer_hs) begin
                        word_cnt  <= word_cnt + 8'd1;
                        stall_cnt <= '0;
                        if (last_word) begin
                            state <= GAP;
                        end
                    end else if (stall_abort) begin
                        state <= PAD;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                PAD: begin
                    word_cnt <= word_cnt + 8'd1;
                    if (last_word) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    job_cnt     <= job_cnt + 16'd1;
                    prefer_src1 <= grant[0];
                    grant       <= 2'b00;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
